wdm_ring_tuner: RTL
===================

WDM_RING_TUNER -- requirements
Module: wdm_ring_tuner

Interface
REQ-001 Parameter N_CH, default 4: number of ring channels tuned.
REQ-002 Parameter HEATER_W, default 8: heater code width per channel.
REQ-003 Parameter PWR_W, default 10: drop-port monitor power width per channel, unsigned.
REQ-004 Parameter STEP, default 4: sweep code increment, 1 <= STEP < 2^HEATER_W.
REQ-005 Parameter DWELL, default 16: thermal settle cycles before each sample, >= 1.
REQ-006 Parameter LOCK_MIN, default 64: minimum power accepted as locked.
REQ-007 clk  in  1  single clock, all state on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 start  in  1  one-cycle request to (re)calibrate all channels.
REQ-010 stop  in  1  abort to IDLE, heater codes held.
REQ-011 pwr_in  in  N_CH*PWR_W  monitor power; channel c at bits [c*PWR_W +: PWR_W].
REQ-012 heater  out  N_CH*HEATER_W  registered heater codes, same packing.
REQ-013 locked  out  N_CH  channel c currently locked.
REQ-014 err  out  N_CH  channel c failed calibration or lost lock; sticky until next start.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 Single shared controller; states IDLE, SWEEP, TRK_REF, TRK_TRY; current channel index ch.
REQ-017 Sampling: pwr_in[ch] is sampled exactly DWELL cycles after the edge that last updated heater[ch] (or entered the state, if no update).
REQ-018 IDLE + start: ch=0, code=0, best_pwr=0, best_code=0, locked=0, err=0, go SWEEP; heater[0]=0 on same edge.
REQ-019 SWEEP codes: 0, STEP, 2*STEP, ... up to largest multiple <= 2^HEATER_W-1; one sample per code.
REQ-020 SWEEP sample p: if p > best_pwr (strict), best_pwr=p, best_code=code; ties keep lower code.
REQ-021 SWEEP end (code+STEP > 2^HEATER_W-1): heater[ch]=best_code; locked[ch]=1 if best_pwr >= LOCK_MIN, else err[ch]=1, heater[ch]=0.
REQ-022 After sweep end: if ch < N_CH-1, ch+1 and restart sweep with best reset; else ch=0, go TRK_REF.
REQ-023 TRK visit of channel with locked[ch]=0: skipped in one cycle, ch advances.
REQ-024 TRK_REF: sample ref; if ref < LOCK_MIN, locked[ch]=0, err[ch]=1, advance; else apply trial code heater[ch]+dir[ch] (dir = +1/-1, reset +1), go TRK_TRY.
REQ-025 Trial out of range (0 or 2^HEATER_W-1 boundary): no trial, flip dir[ch], advance.
REQ-026 TRK_TRY sample p: p > ref keeps trial; else revert to prior code and flip dir[ch]; then advance.
REQ-027 ch advance wraps N_CH-1 -> 0; tracking continues indefinitely.
REQ-028 start in TRK_REF/TRK_TRY restarts calibration as REQ-018; start in SWEEP ignored.
REQ-029 stop in any state: IDLE next edge, heater and locked held, trial in flight not reverted; stop has priority over start.
REQ-030 Only heater[ch] changes per edge; other channels' codes stable.

Reset
REQ-031 rst_n low: immediately heater=0, locked=0, err=0, busy=0, dir=+1 all channels, state IDLE, ch=0, counters 0.
REQ-032 rst_n deassertion mid-sweep or mid-track: resumes from IDLE only; no partial results kept.

Verification (params N_CH=2, HEATER_W=4, STEP=2, DWELL=3, LOCK_MIN=10)
REQ-033 Ch0 model pwr peak 40 at code 6, ch1 peak 30 at code 10 -> heater = {10,6}, locked=2'b11, err=0, sweep 8 samples/channel, each 3 cycles after code change.
REQ-034 Ch1 pwr constant 5 -> ch1 err=1, locked[1]=0, heater[1]=0; ch1 skipped in tracking, ch0 tracks.
REQ-035 Track: after lock at 6, shift ch0 peak to 7 -> heater[0] becomes 7 within two ch0 visits; then oscillating trials revert, code stays 7.
REQ-036 Boundary: ch0 peak at code 14 -> lock 14; trial +1 to 15 allowed, trial beyond 15 never issued, dir flips.
REQ-037 Flat ties (pwr 20 for all codes) -> best_code=0; stop mid-sweep -> IDLE, busy=0 next edge, heater held; rst_n pulse mid-track -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/wdm_ring_tuner.sv
// wdm_ring_tuner: shared sweep-then-dither heater controller locking N_CH micro-ring channels
// to their drop-port power peak.
module wdm_ring_tuner #(
    parameter int N_CH     = 4,
    parameter int HEATER_W = 8,
    parameter int PWR_W    = 10,
    parameter int STEP     = 4,
    parameter int DWELL    = 16,
    parameter int LOCK_MIN = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic [N_CH*PWR_W-1:0]    pwr_in,
    output logic [N_CH*HEATER_W-1:0] heater,
    output logic [N_CH-1:0]          locked,
    output logic [N_CH-1:0]          err,
    output logic                     busy
);
    localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
    localparam int DW = $clog2(DWELL + 1);
    localparam logic [HEATER_W:0]  MAX  = {1'b0, {HEATER_W{1'b1}}};
    localparam logic [PWR_W-1:0]   LOCK = PWR_W'(LOCK_MIN);

    typedef enum logic [1:0] {IDLE, SWEEP, TRK_REF, TRK_TRY} state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              ch_q, ch_d;
    logic [HEATER_W-1:0]        code_q, code_d, best_code_q, best_code_d, prior_q, prior_d;
    logic [PWR_W-1:0]           best_pwr_q, best_pwr_d, ref_q, ref_d;
    logic [DW-1:0]              cnt_q, cnt_d;
    logic                       load_q, load_d;
    logic [N_CH*HEATER_W-1:0]   heater_q, heater_d;
    logic [N_CH-1:0]            locked_q, locked_d, err_q, err_d, dir_q, dir_d;

    logic [PWR_W-1:0]    p, fin_pwr;
    logic [HEATER_W-1:0] h, fin_code, trial;
    logic [HEATER_W:0]   next_code;
    logic [CW-1:0]       ch_nx;
    logic                due, last_ch, better, at_edge;

    assign p         = pwr_in[ch_q*PWR_W +: PWR_W];
    assign h         = heater_q[ch_q*HEATER_W +: HEATER_W];
    assign due       = cnt_q == DW'(DWELL - 1);
    assign last_ch   = ch_q == CW'(N_CH - 1);
    assign ch_nx     = last_ch ? '0 : ch_q + 1'b1;
    assign next_code = {1'b0, code_q} + (HEATER_W+1)'(STEP);
    assign better    = p > best_pwr_q;
    assign fin_pwr   = better ? p : best_pwr_q;
    assign fin_code  = better ? code_q : best_code_q;
    // dir bit set means +1; a trial past either end of the code range is never issued
    assign at_edge   = dir_q[ch_q] ? (h == '1) : (h == '0);
    assign trial     = dir_q[ch_q] ? h + 1'b1 : h - 1'b1;

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        code_d      = code_q;
        best_code_d = best_code_q;
        best_pwr_d  = best_pwr_q;
        prior_d     = prior_q;
        ref_d       = ref_q;
        cnt_d       = cnt_q + 1'b1;
        load_d      = load_q;
        heater_d    = heater_q;
        locked_d    = locked_q;
        err_d       = err_q;
        dir_d       = dir_q;
        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (start && state_q != SWEEP) begin
            state_d              = SWEEP;
            ch_d                 = '0;
            code_d               = '0;
            best_pwr_d           = '0;
            best_code_d          = '0;
            locked_d             = '0;
            err_d                = '0;
            heater_d[HEATER_W-1:0] = '0;
            cnt_d                = '0;
            load_d               = 1'b0;
        end else begin
            case (state_q)
                IDLE: cnt_d = '0;
                SWEEP: begin
                    // the next channel's code 0 is applied one edge after the previous channel settles
                    if (load_q) begin
                        heater_d[ch_q*HEATER_W +: HEATER_W] = '0;
                        load_d = 1'b0;
                        cnt_d  = '0;
                    end else if (due) begin
                        cnt_d       = '0;
                        best_pwr_d  = fin_pwr;
                        best_code_d = fin_code;
                        if (next_code > MAX) begin
                            heater_d[ch_q*HEATER_W +: HEATER_W] = fin_pwr >= LOCK ? fin_code : '0;
                            locked_d[ch_q] = fin_pwr >= LOCK;
                            err_d[ch_q]    = fin_pwr < LOCK;
                            code_d         = '0;
                            best_pwr_d     = '0;
                            best_code_d    = '0;
                            ch_d           = ch_nx;
                            load_d         = !last_ch;
                            state_d        = last_ch ? TRK_REF : SWEEP;
                        end else begin
                            code_d = next_code[HEATER_W-1:0];
                            heater_d[ch_q*HEATER_W +: HEATER_W] = next_code[HEATER_W-1:0];
                        end
                    end
                end
                TRK_REF: begin
                    if (!locked_q[ch_q]) begin
                        ch_d  = ch_nx;
                        cnt_d = '0;
                    end else if (due) begin
                        cnt_d = '0;
                        if (p < LOCK) begin
                            locked_d[ch_q] = 1'b0;
                            err_d[ch_q]    = 1'b1;
                            ch_d           = ch_nx;
                        end else if (at_edge) begin
                            dir_d[ch_q] = !dir_q[ch_q];
                            ch_d        = ch_nx;
                        end else begin
                            ref_d   = p;
                            prior_d = h;
                            heater_d[ch_q*HEATER_W +: HEATER_W] = trial;
                            state_d = TRK_TRY;
                        end
                    end
                end
                TRK_TRY: begin
                    if (due) begin
                        cnt_d   = '0;
                        ch_d    = ch_nx;
                        state_d = TRK_REF;
                        if (p <= ref_q) begin
                            heater_d[ch_q*HEATER_W +: HEATER_W] = prior_q;
                            dir_d[ch_q] = !dir_q[ch_q];
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            code_q      <= '0;
            best_code_q <= '0;
            best_pwr_q  <= '0;
            prior_q     <= '0;
            ref_q       <= '0;
            cnt_q       <= '0;
            load_q      <= 1'b0;
            heater_q    <= '0;
            locked_q    <= '0;
            err_q       <= '0;
            dir_q       <= '1;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            code_q      <= code_d;
            best_code_q <= best_code_d;
            best_pwr_q  <= best_pwr_d;
            prior_q     <= prior_d;
            ref_q       <= ref_d;
            cnt_q       <= cnt_d;
            load_q      <= load_d;
            heater_q    <= heater_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            dir_q       <= dir_d;
        end
    end

    assign heater = heater_q;
    assign locked = locked_q;
    assign err    = err_q;
    assign busy   = state_q != IDLE;
endmodule
